// File: rtl/fp_rsp_arbiter.sv
// Round-robin merge of per-core FP result streams into one registered
// writeback stream: one result per cycle, exactly one cycle of latency.
module fp_rsp_arbiter #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned LANES      = 1,
    parameter int unsigned TAGW       = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_INPUTS-1:0]         valid_in,
    output logic [NUM_INPUTS-1:0]         ready_in,
    input  logic [NUM_INPUTS*LANES*32-1:0] result_in,
    input  logic [NUM_INPUTS-1:0]         has_fflags_in,
    input  logic [NUM_INPUTS*LANES*5-1:0] fflags_in,
    input  logic [NUM_INPUTS*TAGW-1:0]    tag_in,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic [LANES*32-1:0]           result,
    output logic                          has_fflags,
    output logic [LANES*5-1:0]            fflags,
    output logic [TAGW-1:0]               tag_out
);

    localparam int unsigned PTRW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic [LANES*32-1:0] res_arr [NUM_INPUTS];
    logic [LANES*5-1:0]  ff_arr  [NUM_INPUTS];
    logic [TAGW-1:0]     tag_arr [NUM_INPUTS];

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
        assign res_arr[gi] = result_in[gi*LANES*32 +: LANES*32];
        assign ff_arr[gi]  = fflags_in[gi*LANES*5 +: LANES*5];
        assign tag_arr[gi] = tag_in[gi*TAGW +: TAGW];
    end

    logic [PTRW-1:0]     rr_ptr_q, rr_ptr_d;
    logic                valid_q, valid_d;
    logic [LANES*32-1:0] result_q, result_d;
    logic                has_fflags_q, has_fflags_d;
    logic [LANES*5-1:0]  fflags_q, fflags_d;
    logic [TAGW-1:0]     tag_q, tag_d;

    logic [PTRW-1:0] grant;
    logic            found;
    logic            accept;
    logic            fire;
    int unsigned     idx;

    // Scan starts at rr_ptr and wraps, so the first valid index found is the grant.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_INPUTS) begin
                idx = idx - NUM_INPUTS;
            end
            if (!found && valid_in[PTRW'(idx)]) begin
                found = 1'b1;
                grant = PTRW'(idx);
            end
        end
    end

    assign accept = ~valid_q | ready_out;
    assign fire   = found & accept;

    always_comb begin
        ready_in = '0;
        if (found) begin
            ready_in[grant] = accept;
        end
    end

    always_comb begin
        valid_d      = valid_q;
        result_d     = result_q;
        has_fflags_d = has_fflags_q;
        fflags_d     = fflags_q;
        tag_d        = tag_q;
        rr_ptr_d     = rr_ptr_q;
        if (fire) begin
            valid_d      = 1'b1;
            result_d     = res_arr[grant];
            has_fflags_d = has_fflags_in[grant];
            fflags_d     = has_fflags_in[grant] ? ff_arr[grant] : '0;
            tag_d        = tag_arr[grant];
            rr_ptr_d     = (grant == PTRW'(NUM_INPUTS - 1)) ? '0 : grant + PTRW'(1);
        end else if (ready_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            result_q     <= '0;
            has_fflags_q <= 1'b0;
            fflags_q     <= '0;
            tag_q        <= '0;
            rr_ptr_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            result_q     <= result_d;
            has_fflags_q <= has_fflags_d;
            fflags_q     <= fflags_d;
            tag_q        <= tag_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign valid_out  = valid_q;
    assign result     = result_q;
    assign has_fflags = has_fflags_q;
    assign fflags     = fflags_q;
    assign tag_out    = tag_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(ready_in));
            assert (!$isunknown(valid_out));
        end
    end
`endif

endmodule

// File: tb/tb_fp_rsp_arbiter.sv
// Directed bench for fp_rsp_arbiter (NUM_INPUTS=4, LANES=1, TAGW=1) with
// hand-computed expected grants and output beats.
module tb_fp_rsp_arbiter;

    localparam int unsigned N = 4;

    logic          clk;
    logic          reset;
    logic [N-1:0]  valid_in;
    logic [N-1:0]  ready_in;
    logic [N*32-1:0] result_in;
    logic [N-1:0]  has_fflags_in;
    logic [N*5-1:0] fflags_in;
    logic [N-1:0]  tag_in;
    logic          valid_out;
    logic          ready_out;
    logic [31:0]   result;
    logic          has_fflags;
    logic [4:0]    fflags;
    logic [0:0]    tag_out;

    logic [31:0] core_res [N];
    logic [4:0]  core_ff  [N];
    logic        core_hf  [N];
    logic        core_tag [N];

    int errors = 0;
    int checks = 0;

    fp_rsp_arbiter #(
        .NUM_INPUTS(N),
        .LANES     (1),
        .TAGW      (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .result_in    (result_in),
        .has_fflags_in(has_fflags_in),
        .fflags_in    (fflags_in),
        .tag_in       (tag_in),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .result       (result),
        .has_fflags   (has_fflags),
        .fflags       (fflags),
        .tag_out      (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        result_in     = '0;
        fflags_in     = '0;
        has_fflags_in = '0;
        tag_in        = '0;
        for (int c = 0; c < N; c++) begin
            result_in[c*32 +: 32] = core_res[c];
            fflags_in[c*5 +: 5]   = core_ff[c];
            has_fflags_in[c]      = core_hf[c];
            tag_in[c]             = core_tag[c];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are checked 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic load_default_cores();
        for (int c = 0; c < N; c++) begin
            core_res[c] = 32'h1000 + 32'(c);
            core_ff[c]  = 5'(c + 1);
            core_hf[c]  = 1'b1;
            core_tag[c] = c[0];
        end
    endtask

    task automatic check_beat(input string tag, input int c);
        check({tag, ".valid"}, 64'(valid_out), 64'd1);
        check({tag, ".result"}, 64'(result), 64'h1000 + 64'(c));
        check({tag, ".tag"}, 64'(tag_out), 64'(c % 2));
        check({tag, ".fflags"}, 64'(fflags), 64'(c + 1));
    endtask

    initial begin
        reset     = 1'b1;
        valid_in  = '0;
        ready_out = 1'b1;
        load_default_cores();
        step();
        step();
        reset = 1'b0;

        // 1: idle after reset
        for (int k = 0; k < 20; k++) begin
            step();
            check("idle.valid_out", 64'(valid_out), 64'd0);
            check("idle.ready_in", 64'(ready_in), 64'd0);
            check("idle.result", 64'(result), 64'd0);
            check("idle.fflags", 64'(fflags), 64'd0);
        end

        // 2: single core 2
        core_res[2] = 32'h40490fdb;
        core_tag[2] = 1'b1;
        core_hf[2]  = 1'b1;
        core_ff[2]  = 5'b00001;
        valid_in    = 4'b0100;
        settle();
        check("single.ready_in", 64'(ready_in), 64'b0100);
        check("single.pre_valid", 64'(valid_out), 64'd0);
        step();
        valid_in = '0;
        check("single.valid_out", 64'(valid_out), 64'd1);
        check("single.result", 64'(result), 64'h40490fdb);
        check("single.tag", 64'(tag_out), 64'd1);
        check("single.has_fflags", 64'(has_fflags), 64'd1);
        check("single.fflags", 64'(fflags), 64'b00001);
        load_default_cores();

        // rr_ptr is now 3: with all valid, core 3 wins first
        valid_in = 4'b1111;
        settle();
        check("ptr3.ready_in", 64'(ready_in), 64'b1000);
        step();
        check_beat("ptr3.beat", 3);

        // 3: all valid, back-to-back 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            settle();
            check("rr.ready_in", 64'(ready_in), 64'(1) << (k % 4));
            step();
            check_beat("rr.beat", k % 4);
        end

        // 4: FULL (core 3 beat) and stalled while cores 1 and 3 are valid
        valid_in  = 4'b1010;
        ready_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("stall.ready_in", 64'(ready_in), 64'd0);
            step();
            check_beat("stall.hold", 3);
        end
        ready_out = 1'b1;
        settle();
        check("unstall.ready_in", 64'(ready_in), 64'b0010);
        step();
        check_beat("unstall.beat", 1);
        valid_in = 4'b1000;
        settle();
        check("unstall2.ready_in", 64'(ready_in), 64'b1000);
        step();
        check_beat("unstall2.beat", 3);
        valid_in = '0;
        step();
        check("drain.valid_out", 64'(valid_out), 64'd0);

        // 5: fflags masked when has_fflags_in=0
        core_res[0] = 32'h12345678;
        core_hf[0]  = 1'b0;
        core_ff[0]  = 5'b11111;
        valid_in    = 4'b0001;
        settle();
        check("mask.ready_in", 64'(ready_in), 64'b0001);
        step();
        valid_in = '0;
        check("mask.valid_out", 64'(valid_out), 64'd1);
        check("mask.result", 64'(result), 64'h12345678);
        check("mask.has_fflags", 64'(has_fflags), 64'd0);
        check("mask.fflags", 64'(fflags), 64'd0);
        load_default_cores();

        // 6: reset while FULL and stalled
        ready_out = 1'b0;
        valid_in  = 4'b0100;
        settle();
        check("rst.pre_valid", 64'(valid_out), 64'd1);
        check("rst.pre_ready_in", 64'(ready_in), 64'd0);
        step();
        reset    = 1'b1;
        valid_in = '0;
        step();
        reset = 1'b0;
        check("rst.valid_out", 64'(valid_out), 64'd0);
        check("rst.result", 64'(result), 64'd0);
        check("rst.has_fflags", 64'(has_fflags), 64'd0);
        ready_out = 1'b1;
        valid_in  = 4'b1111;
        settle();
        check("rst.ready_in", 64'(ready_in), 64'b0001);
        step();
        check_beat("rst.beat", 0);
        valid_in = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
